// File: rtl/mmio_uart_transmitter.sv
// Memory-mapped 8N1 UART transmitter: CPU stores feed a TX FIFO that an FSM serialises onto tx.
// Define UART_TX_PARITY_EN to add the CONFIG register and an optional parity bit per frame.
module mmio_uart_transmitter #(
    parameter logic [31:0] BASE_ADDRESS   = 32'hFFFF_0000,
    parameter int unsigned CLOCKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        memory_write_en,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_value,
    output logic [31:0] memory_read_value,
    output logic        select,
    output logic        tx,
    output logic        busy
);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned TimerW = $clog2(CLOCKS_PER_BIT);
    localparam logic [TimerW-1:0] BitReload = TimerW'(CLOCKS_PER_BIT - 1);
    localparam logic [CntW-1:0]   DepthVal  = CntW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    // Address decode
    logic [31:0] offset;
    logic [1:0]  reg_index;
    logic        data_write;
    logic        status_write;

    // Out-of-window addresses wrap to large offsets, so one compare covers both bounds.
    assign offset       = memory_address - BASE_ADDRESS;
    assign select       = (offset < 32'd12);
    assign reg_index    = offset[3:2];
    assign data_write   = memory_write_en && select && (reg_index == 2'd0);
    assign status_write = memory_write_en && select && (reg_index == 2'd1);

    logic unused_write_bits;
    assign unused_write_bits = ^memory_write_value[31:8];

    // TX FIFO
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            overflow;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push_accept;
    logic            pop;
    logic [7:0]      fifo_head;

    state_e           state;
    logic [TimerW-1:0] bit_timer;
    logic [2:0]       bit_index;
    logic [7:0]       shifter;

    assign fifo_full   = (count == DepthVal);
    assign fifo_empty  = (count == '0);
    assign fifo_head   = fifo_mem[rd_ptr];
    assign pop         = !fifo_empty &&
                         ((state == StIdle) || ((state == StStop) && (bit_timer == '0)));
    // A pop frees the head slot this cycle, so a push at full can land in it.
    assign push_accept = data_write && (!fifo_full || pop);

    always_ff @(posedge clock) begin
        if (push_accept) begin
            fifo_mem[wr_ptr] <= memory_write_value[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            if (push_accept && !pop) begin
                count <= count + CntW'(1);
            end else if (!push_accept && pop) begin
                count <= count - CntW'(1);
            end
            if (data_write && !push_accept) begin
                overflow <= 1'b1;
            end else if (status_write && memory_write_value[3]) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic config_write;
    logic parity_enable;
    logic parity_odd;
    logic frame_parity_en;
    logic frame_parity_bit;

    assign config_write = memory_write_en && select && (reg_index == 2'd2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parity_enable <= 1'b0;
            parity_odd    <= 1'b0;
        end else if (config_write) begin
            parity_enable <= memory_write_value[0];
            parity_odd    <= memory_write_value[1];
        end
    end
`endif

    // Serialiser FSM; tx and busy are registered alongside the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            bit_timer <= '0;
            bit_index <= '0;
            shifter   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            frame_parity_en  <= 1'b0;
            frame_parity_bit <= 1'b0;
`endif
        end else if (pop) begin
            state     <= StStart;
            bit_timer <= BitReload;
            bit_index <= '0;
            shifter   <= fifo_head;
            tx        <= 1'b0;
            busy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            // CONFIG is latched per frame so mid-frame writes only affect the next one.
            frame_parity_en  <= parity_enable;
            frame_parity_bit <= (^fifo_head) ^ parity_odd;
`endif
        end else begin
            case (state)
                StIdle: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                end
                StStart: begin
                    if (bit_timer == '0) begin
                        state     <= StData;
                        bit_timer <= BitReload;
                        bit_index <= '0;
                        tx        <= shifter[0];
                    end else begin
                        bit_timer <= bit_timer - TimerW'(1);
                    end
                end
                StData: begin
                    if (bit_timer == '0) begin
                        bit_timer <= BitReload;
                        if (bit_index == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (frame_parity_en) begin
                                state <= StParity;
                                tx    <= frame_parity_bit;
                            end else begin
                                state <= StStop;
                                tx    <= 1'b1;
                            end
`else
                            state <= StStop;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_index <= bit_index + 3'd1;
                            shifter   <= shifter >> 1;
                            tx        <= shifter[1];
                        end
                    end else begin
                        bit_timer <= bit_timer - TimerW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_timer == '0) begin
                        state     <= StStop;
                        bit_timer <= BitReload;
                        tx        <= 1'b1;
                    end else begin
                        bit_timer <= bit_timer - TimerW'(1);
                    end
                end
`endif
                StStop: begin
                    // The non-empty case on the last stop cycle is handled by the pop branch.
                    if (bit_timer == '0) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        tx    <= 1'b1;
                    end else begin
                        bit_timer <= bit_timer - TimerW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Combinational read-back
    always_comb begin
        memory_read_value = '0;
        if (select) begin
            case (reg_index)
                2'd1: memory_read_value = {16'h0, 8'(count), 4'h0, overflow, busy,
                                           fifo_empty, fifo_full};
`ifdef UART_TX_PARITY_EN
                2'd2: memory_read_value = {30'h0, parity_odd, parity_enable};
`endif
                default: memory_read_value = '0;
            endcase
        end
    end

endmodule
